dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 32x256 data memory. Two requesters (port 0: core load/store path, port 1: secondary master such as a loader or debug port) issue single-word read/write commands; the arbiter selects one, drives the memory for exactly one cycle, and returns read data or a write acknowledge. It sits between the requesters and the memory's `write_data`/`read_data`/`address`/`read_en`/`write_en` pins and is the only block that drives them.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the 32x256 data memory.
// Tie rule: DMEM_ARB_RR_EN defined = round-robin, undefined = port 0 priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_read_data
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitrates and latches the winner
  // ACCESS | memory enables and winner's gnt high for one cycle
  // RESP   | winner's rvalid high, rdata_q valid
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        cmd_idx;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rdata_q;
  logic        last_grant;
  logic        tie_pick;
  logic        win;
  logic        win_we;

`ifdef DMEM_ARB_RR_EN
  assign tie_pick = ~last_grant;
`else
  // last_grant is still tracked, but a tie always goes to port 0
  assign tie_pick = last_grant & 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) win = tie_pick;
    else if (m1_req)      win = 1'b1;
  end

  assign win_we = win ? m1_we : m0_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_idx      <= 1'b0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      rdata_q      <= '0;
      last_grant   <= 1'b1;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            cmd_idx      <= win;
            cmd_we       <= win_we;
            cmd_addr     <= win ? m1_addr  : m0_addr;
            cmd_wdata    <= win ? m1_wdata : m0_wdata;
            m0_gnt       <= ~win;
            m1_gnt       <= win;
            mem_write_en <= win_we;
            mem_read_en  <= ~win_we;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cmd_we) rdata_q <= mem_read_data;
          m0_gnt       <= 1'b0;
          m1_gnt       <= 1'b0;
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          m0_rvalid    <= ~cmd_idx;
          m1_rvalid    <= cmd_idx;
          state        <= RESP;
        end
        RESP: begin
          m0_rvalid  <= 1'b0;
          m1_rvalid  <= 1'b0;
          last_grant <= cmd_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_address    = cmd_addr;
  assign mem_write_data = cmd_wdata;
  assign m0_rdata       = rdata_q;
  assign m1_rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x256 memory attached.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read_en, mem_write_en;

  logic [31:0] mem [256];
  int          vectors = 0;
  int          errors  = 0;
  logic        both_en = 1'b0;
  logic        rr;
  logic        exp_w;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[7:0]] <= mem_write_data;
  always @(negedge clk) if (mem_read_en && mem_write_en) both_en <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_gnt",    {30'd0, m0_gnt, m1_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rst_en",     {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_addr",   mem_address, 32'd0);
    chk("rst_wdata",  mem_write_data, 32'd0);
    chk("rst_rdata",  m0_rdata, 32'd0);

    // port 0 write 0xDEADBEEF -> 0x05
    m0_req = 1; m0_we = 1; m0_addr = 32'h05; m0_wdata = 32'hDEADBEEF;
    step();
    m0_req = 0;
    chk("w0_gnt",   {30'd0, m0_gnt, m1_gnt}, 32'd2);
    chk("w0_en",    {30'd0, mem_read_en, mem_write_en}, 32'd1);
    chk("w0_addr",  mem_address, 32'h05);
    chk("w0_wdata", mem_write_data, 32'hDEADBEEF);
    step();
    chk("w0_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("w0_gnt_off", {29'd0, m0_gnt, mem_read_en, mem_write_en}, 32'd0);
    chk("w0_mem",   mem[5], 32'hDEADBEEF);
    step();

    // port 0 read 0x05
    m0_req = 1; m0_we = 0; m0_addr = 32'h05;
    step();
    m0_req = 0;
    chk("r0_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    chk("r0_en",  {30'd0, mem_read_en, mem_write_en}, 32'd2);
    step();
    chk("r0_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("r0_rdata",  m0_rdata, 32'hDEADBEEF);
    step();

    // port 1 write 0x107 -> 0x107 (memory decodes word 0x07); rdata_q must hold
    m1_req = 1; m1_we = 1; m1_addr = 32'h107; m1_wdata = 32'h0000_0107;
    step();
    m1_req = 0;
    chk("w1_gnt",  {30'd0, m0_gnt, m1_gnt}, 32'd1);
    chk("w1_addr", mem_address, 32'h107);
    step();
    chk("w1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
    chk("w1_mem",    mem[7], 32'h0000_0107);
    chk("w1_rhold",  m1_rdata, 32'hDEADBEEF);
    step();

    // port 1 read of unwritten 0x10
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    step();
    m1_req = 0;
    chk("r1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd1);
    step();
    chk("r1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
    chk("r1_rdata",  m1_rdata, 32'd0);
    step();

    // both ports hold req: last_grant is 1 here, so port 0 wins the first tie
    m0_req = 1; m0_we = 0; m0_addr = 32'h05;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      exp_w = rr & k[0];
      step();
      chk($sformatf("tie%0d_gnt", k), {30'd0, m0_gnt, m1_gnt}, exp_w ? 32'd1 : 32'd2);
      step();
      chk($sformatf("tie%0d_rvalid", k), {30'd0, m0_rvalid, m1_rvalid}, exp_w ? 32'd1 : 32'd2);
      chk($sformatf("tie%0d_rdata", k), m0_rdata, exp_w ? 32'd0 : 32'hDEADBEEF);
      step();
    end
    m0_req = 0; m1_req = 0;
    step();
    chk("idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // reset asserted during the ACCESS cycle of a port 0 write to 0x20
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hCAFE0020;
    step();
    m0_req = 0;
    chk("rw_gnt", {30'd0, m0_gnt, mem_write_en}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_mem",    mem[32], 32'hCAFE0020);
    chk("rw_outs",   {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read_en, mem_write_en}, 32'd0);
    chk("rw_addr",   mem_address, 32'd0);
    chk("rw_rdata",  m0_rdata, 32'd0);
    step();
    chk("rw_norv",   {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rw_idle",   {30'd0, m0_gnt, m1_gnt}, 32'd0);

    chk("en_excl", {31'd0, both_en}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
